// File: rtl/mac_rx_pkg.sv
// mac_rx_pkg: constants and state encodings shared by the mac_rx read controller
// and its helpers.
//   FRAME_W          - width of one reader result / output frame in bits
//   DEF_FRAME_BYTES  - default FIFO occupancy needed before a read may start
//   DEF_READ_NUM     - default byte-count configuration driven to the reader
//   DEF_HDR_BYTE     - default required first byte of an accepted frame
//   state_t + IDLE..ABORT - read sequencer state encodings (3-bit)
package mac_rx_pkg;

    localparam int unsigned FRAME_W         = 96;
    localparam int unsigned DEF_FRAME_BYTES = 12;
    localparam logic [11:0] DEF_READ_NUM    = 12'd11;
    localparam logic [7:0]  DEF_HDR_BYTE    = 8'hAA;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t START   = 3'd1;
    localparam state_t BUSY    = 3'd2;
    localparam state_t RELEASE = 3'd3;
    localparam state_t ABORT   = 3'd4;

endpackage

// File: rtl/mac_rx_sat_cnt16.sv
// mac_rx_sat_cnt16: 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
//   i_clk  - clock, all logic on posedge
//   i_clr  - synchronous clear, loads CLR_VAL (wins over i_inc)
//   i_inc  - count one event this cycle
//   o_cnt  - current count
module mac_rx_sat_cnt16 #(
    parameter logic [15:0] CLR_VAL = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [15:0] o_cnt
);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= CLR_VAL;
        end else if (i_inc && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mac_rx_read_ctrl.sv
// mac_rx_read_ctrl: frame-level sequencer for the mac_rx FIFO reader.
// Starts a read (fs) once a full frame sits in the RX FIFO, waits for the reader's
// frame-done (fd), checks the header byte of the 96-bit result and offers accepted
// frames downstream on a valid/ready handshake. Reads that never finish are aborted.
//   i_clk, i_rst  - clock and synchronous active-high reset
//   i_en          - permits new reads; an in-flight read always completes
//   i_fifo_count  - RX FIFO occupancy in bytes (sampled only while idle)
//   o_fifo_num    - reader byte-count configuration, constant READ_NUM
//   o_rd_fs       - frame-start request to the reader (START/BUSY)
//   i_rd_fd       - frame-done from the reader
//   o_rd_err      - one-cycle abort pulse to the reader
//   i_rd_res      - reader result; reader bit 0 (MSB of byte 0) is i_rd_res[95]
//   o_out_data    - accepted frame, held while o_out_valid && !i_out_ready
//   o_out_valid   - o_out_data valid
//   i_out_ready   - downstream accept
//   o_frame_cnt   - accepted frames (saturating)
//   o_drop_cnt    - header-mismatch frames (saturating)
//   o_tout_cnt    - timed-out reads (saturating)
module mac_rx_read_ctrl
    import mac_rx_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = DEF_FRAME_BYTES,
    parameter logic [11:0] READ_NUM    = DEF_READ_NUM,
    parameter logic [7:0]  HDR_BYTE    = DEF_HDR_BYTE,
    parameter int unsigned TIMEOUT     = 1024,
    // Value the statistics counters take on reset
    parameter logic [15:0] CNT_INIT    = 16'h0000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [11:0]        i_fifo_count,
    output logic [11:0]        o_fifo_num,
    output logic               o_rd_fs,
    input  logic               i_rd_fd,
    output logic               o_rd_err,
    input  logic [FRAME_W-1:0] i_rd_res,
    output logic [FRAME_W-1:0] o_out_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [15:0]        o_frame_cnt,
    output logic [15:0]        o_drop_cnt,
    output logic [15:0]        o_tout_cnt
);

    state_t              r_state;
    state_t              w_state_d;
    logic [15:0]         r_timer;
    logic                r_out_valid;
    logic [FRAME_W-1:0]  r_out_data;

    logic                w_fifo_ok;
    logic                w_timer_exp;
    logic                w_hdr_ok;
    logic                w_rd_fs;
    logic                w_rd_err;
    logic                w_frame_inc;
    logic                w_drop_inc;
    logic                w_tout_inc;

    assign w_fifo_ok   = (i_fifo_count >= 12'(FRAME_BYTES));
    assign w_timer_exp = (r_timer == 16'(TIMEOUT - 1));
    // Reader numbers bits MSB-first, so its byte 0 is the top byte of the vector
    assign w_hdr_ok    = (i_rd_res[FRAME_W-1 -: 8] == HDR_BYTE);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = IDLE;
        case (r_state)
            IDLE: begin
                // Only one frame is ever held, so a pending output blocks a new read
                if (i_en && !r_out_valid && w_fifo_ok) begin
                    w_state_d = START;
                end else begin
                    w_state_d = IDLE;
                end
            end
            START: w_state_d = BUSY;
            BUSY: begin
                // Frame-done takes priority over an expiring timer
                if (i_rd_fd) begin
                    w_state_d = RELEASE;
                end else if (w_timer_exp) begin
                    w_state_d = ABORT;
                end else begin
                    w_state_d = BUSY;
                end
            end
            ABORT: w_state_d = RELEASE;
            RELEASE: begin
                // The reader drops fd once it sees fs low, so no timeout here
                if (i_rd_fd) begin
                    w_state_d = RELEASE;
                end else begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Output / event decode
    always_comb begin
        w_rd_fs     = 1'b0;
        w_rd_err    = 1'b0;
        w_frame_inc = 1'b0;
        w_drop_inc  = 1'b0;
        w_tout_inc  = 1'b0;
        case (r_state)
            START: w_rd_fs = 1'b1;
            BUSY: begin
                w_rd_fs     = 1'b1;
                w_frame_inc = i_rd_fd && w_hdr_ok;
                w_drop_inc  = i_rd_fd && !w_hdr_ok;
            end
            ABORT: begin
                w_rd_err   = 1'b1;
                w_tout_inc = 1'b1;
            end
            default: ;
        endcase
    end

    // Read timer: cleared in START, counts every BUSY cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timer <= 16'd0;
        end else if (r_state == START) begin
            r_timer <= 16'd0;
        end else if (r_state == BUSY) begin
            r_timer <= r_timer + 16'd1;
        end
    end

    // Output holding register; a capture can never coincide with a handshake
    // because reads only start while nothing is held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_frame_inc) begin
                r_out_valid <= 1'b1;
                r_out_data  <= i_rd_res;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    mac_rx_sat_cnt16 #(
        .CLR_VAL (CNT_INIT)
    ) u_frame_cnt (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_inc (w_frame_inc),
        .o_cnt (o_frame_cnt)
    );

    mac_rx_sat_cnt16 #(
        .CLR_VAL (CNT_INIT)
    ) u_drop_cnt (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_inc (w_drop_inc),
        .o_cnt (o_drop_cnt)
    );

    mac_rx_sat_cnt16 #(
        .CLR_VAL (CNT_INIT)
    ) u_tout_cnt (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_inc (w_tout_inc),
        .o_cnt (o_tout_cnt)
    );

    assign o_fifo_num  = READ_NUM;
    assign o_rd_fs     = w_rd_fs;
    assign o_rd_err    = w_rd_err;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_mac_rx_read_ctrl.sv
// tb_mac_rx_read_ctrl: directed bench for mac_rx_read_ctrl. Two instances share all
// inputs; the second resets its counters to 16'hFFFF to exercise saturation.
module tb_mac_rx_read_ctrl;

    localparam logic [95:0] GOOD1 = 96'hAA0102030405060708090A0B;
    localparam logic [95:0] BAD1  = 96'h55A1A2A3A4A5A6A7A8A9AAAB;
    localparam logic [95:0] GOOD2 = 96'hAAFFEEDDCCBBAA9988776655;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] fifo_count;
    logic        rd_fd;
    logic [95:0] rd_res;
    logic        out_ready;

    logic [11:0] fifo_num,  s_fifo_num;
    logic        rd_fs,     s_rd_fs;
    logic        rd_err,    s_rd_err;
    logic [95:0] out_data,  s_out_data;
    logic        out_valid, s_out_valid;
    logic [15:0] frame_cnt, s_frame_cnt;
    logic [15:0] drop_cnt,  s_drop_cnt;
    logic [15:0] tout_cnt,  s_tout_cnt;

    int n_vec;
    int n_miss;

    mac_rx_read_ctrl #(
        .TIMEOUT  (16),
        .CNT_INIT (16'h0000)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_fifo_count (fifo_count),
        .o_fifo_num   (fifo_num),
        .o_rd_fs      (rd_fs),
        .i_rd_fd      (rd_fd),
        .o_rd_err     (rd_err),
        .i_rd_res     (rd_res),
        .o_out_data   (out_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_frame_cnt  (frame_cnt),
        .o_drop_cnt   (drop_cnt),
        .o_tout_cnt   (tout_cnt)
    );

    mac_rx_read_ctrl #(
        .TIMEOUT  (16),
        .CNT_INIT (16'hFFFF)
    ) dut_sat (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_fifo_count (fifo_count),
        .o_fifo_num   (s_fifo_num),
        .o_rd_fs      (s_rd_fs),
        .i_rd_fd      (rd_fd),
        .o_rd_err     (s_rd_err),
        .i_rd_res     (rd_res),
        .o_out_data   (s_out_data),
        .o_out_valid  (s_out_valid),
        .i_out_ready  (out_ready),
        .o_frame_cnt  (s_frame_cnt),
        .o_drop_cnt   (s_drop_cnt),
        .o_tout_cnt   (s_tout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are observed at the falling edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        rst        = 1'b1;
        en         = 1'b0;
        fifo_count = 12'd0;
        rd_fd      = 1'b0;
        rd_res     = '0;
        out_ready  = 1'b0;
        step(2);

        // Reset state
        check_vec("rst_fs",       96'(rd_fs),     96'(0));
        check_vec("rst_err",      96'(rd_err),    96'(0));
        check_vec("rst_valid",    96'(out_valid), 96'(0));
        check_vec("rst_data",     out_data,       96'(0));
        check_vec("rst_frame",    96'(frame_cnt), 96'(0));
        check_vec("rst_drop",     96'(drop_cnt),  96'(0));
        check_vec("rst_tout",     96'(tout_cnt),  96'(0));
        check_vec("rst_fifo_num", 96'(fifo_num),  96'(11));
        rst = 1'b0;

        // Start gating: 11 bytes never starts a read
        en         = 1'b1;
        fifo_count = 12'd11;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_vec("gate_11_fs", 96'(rd_fs), 96'(0));
        end
        fifo_count = 12'd12;
        step(1);
        check_vec("gate_12_fs", 96'(rd_fs), 96'(1));   // START

        // Good frame: fd after 14 BUSY cycles (timeout at 16)
        fifo_count = 12'd0;
        rd_res     = GOOD1;
        for (int i = 0; i < 14; i++) begin
            step(1);
            check_vec("busy_fs", 96'(rd_fs), 96'(1));
        end
        rd_fd = 1'b1;
        step(1);                                        // RELEASE
        check_vec("good_valid", 96'(out_valid), 96'(1));
        check_vec("good_data",  out_data,       GOOD1);
        check_vec("good_frame", 96'(frame_cnt), 96'(1));
        check_vec("good_fs",    96'(rd_fs),     96'(0));
        check_vec("sat_frame",  96'(s_frame_cnt), 96'(16'hFFFF));
        step(1);                                        // still RELEASE, fd high
        check_vec("rel_fs",     96'(rd_fs),  96'(0));
        check_vec("rel_err",    96'(rd_err), 96'(0));
        rd_fd = 1'b0;
        step(1);                                        // IDLE, frame held
        out_ready = 1'b1;
        step(1);
        check_vec("hs1_valid", 96'(out_valid), 96'(0));
        out_ready = 1'b0;

        // Bad header
        fifo_count = 12'd12;
        rd_res     = BAD1;
        step(1);
        check_vec("bad_start_fs", 96'(rd_fs), 96'(1)); // START
        fifo_count = 12'd0;
        step(1);                                        // BUSY
        rd_fd = 1'b1;
        step(1);                                        // RELEASE
        check_vec("bad_valid", 96'(out_valid), 96'(0));
        check_vec("bad_drop",  96'(drop_cnt),  96'(1));
        check_vec("bad_frame", 96'(frame_cnt), 96'(1));
        check_vec("bad_data",  out_data,       GOOD1);
        check_vec("sat_drop",  96'(s_drop_cnt), 96'(16'hFFFF));
        rd_fd = 1'b0;
        step(1);                                        // IDLE

        // Backpressure: frame held, plenty of data buffered
        fifo_count = 12'd40;
        rd_res     = GOOD2;
        step(1);
        check_vec("bp_start_fs", 96'(rd_fs), 96'(1));  // START
        step(1);                                        // BUSY
        rd_fd = 1'b1;
        step(1);                                        // RELEASE
        check_vec("bp_valid", 96'(out_valid), 96'(1));
        check_vec("bp_frame", 96'(frame_cnt), 96'(2));
        rd_fd  = 1'b0;
        rd_res = BAD1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            check_vec("bp_hold_fs",   96'(rd_fs), 96'(0));
            check_vec("bp_hold_data", out_data,   GOOD2);
        end
        out_ready = 1'b1;
        step(1);                                        // handshake; IDLE does not start
        check_vec("bp_hs_valid", 96'(out_valid), 96'(0));
        check_vec("bp_hs_fs",    96'(rd_fs),     96'(0));
        out_ready = 1'b0;
        step(1);
        check_vec("bp_restart_fs", 96'(rd_fs), 96'(1)); // START one cycle later

        // Timeout on this read: fd stays low
        fifo_count = 12'd0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            check_vec("to_busy_fs",  96'(rd_fs),  96'(1));
            check_vec("to_busy_err", 96'(rd_err), 96'(0));
        end
        step(1);                                        // ABORT
        check_vec("to_abort_fs",  96'(rd_fs),  96'(0));
        check_vec("to_abort_err", 96'(rd_err), 96'(1));
        step(1);                                        // RELEASE
        check_vec("to_rel_err",  96'(rd_err),   96'(0));
        check_vec("to_rel_fs",   96'(rd_fs),    96'(0));
        check_vec("to_cnt",      96'(tout_cnt), 96'(1));
        check_vec("sat_tout",    96'(s_tout_cnt), 96'(16'hFFFF));
        step(1);                                        // IDLE

        // Reset mid-read
        fifo_count = 12'd12;
        step(1);                                        // START
        step(1);                                        // BUSY
        check_vec("mid_busy_fs", 96'(rd_fs), 96'(1));
        rst = 1'b1;
        step(1);
        check_vec("mid_rst_fs",    96'(rd_fs),     96'(0));
        check_vec("mid_rst_err",   96'(rd_err),    96'(0));
        check_vec("mid_rst_valid", 96'(out_valid), 96'(0));
        check_vec("mid_rst_data",  out_data,       96'(0));
        check_vec("mid_rst_frame", 96'(frame_cnt), 96'(0));
        check_vec("mid_rst_drop",  96'(drop_cnt),  96'(0));
        check_vec("mid_rst_tout",  96'(tout_cnt),  96'(0));
        rst = 1'b0;

        // en low: no read starts even with data buffered
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check_vec("en_low_fs", 96'(rd_fs), 96'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mac_rx_read_ctrl.md
Name: mac_rx_read_ctrl

Overview:
- Frame-level sequencer for the mac_rx FIFO reader block.
- Watches the RX FIFO fill level and issues fs to the reader once a full frame is buffered; the reader's LAST state waits for fs to drop before returning to idle.
- Waits for fd, captures the reader's 96-bit result, checks the header byte and presents accepted frames downstream on a valid/ready handshake.
- Aborts and counts reads that never complete.

Parameters:
- FRAME_BYTES, 12, minimum fifo_count that allows a read to start.
- READ_NUM, 12'd11, constant driven on fifo_num (the reader's byte-count configuration).
- HDR_BYTE, 8'hAA, required value of result bits [0:7], the first byte.
- TIMEOUT, 1024, maximum cycles allowed in BUSY before abort (16-bit counter).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  allows new reads to start; an in-flight read always completes.
- fifo_count  in  12  RX FIFO occupancy in bytes, unsigned.
- fifo_num  out  12  reader byte-count configuration; constant READ_NUM.
- rd_fs  out  1  frame-start request to the reader.
- rd_fd  in  1  frame-done from the reader; sampled on posedge clk.
- rd_err  out  1  one-cycle abort pulse to the reader.
- rd_res  in  96  reader result, bit 0 = MSB of byte 0.
- out_data  out  96  accepted frame.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- frame_cnt  out  16  accepted frames, saturating.
- drop_cnt  out  16  header-mismatch frames, saturating.
- tout_cnt  out  16  timed-out reads, saturating.

Behaviour:
- Reset (synchronous): state IDLE, timer 0; rd_fs, rd_err, out_valid 0; out_data 0; all counters 0; fifo_num = READ_NUM at all times.
- rd_fs = (state == START or BUSY). rd_err is asserted only in ABORT.
- IDLE -> START when en && !out_valid && fifo_count >= FRAME_BYTES.
- START: lasts exactly 1 cycle; clears the timer; -> BUSY.
- BUSY: timer increments each cycle.
  - If rd_fd == 1: capture rd_res and go to RELEASE.
    - If rd_res[0:7] == HDR_BYTE: out_data <= rd_res, out_valid <= 1, frame_cnt++.
    - Otherwise: drop_cnt++, out_data unchanged.
  - Else if timer == TIMEOUT-1: -> ABORT. rd_fd wins if both conditions hold in the same cycle.
- ABORT: 1 cycle; rd_fs 0, rd_err 1, tout_cnt++; -> RELEASE.
- RELEASE: rd_fs 0; -> IDLE when rd_fd == 0. RELEASE has no timeout, because the reader drops fd once it sees fs low.
- Latency: rd_fd high in BUSY -> out_valid high on the next posedge.
- Output handshake:
  - out_valid clears on the cycle where out_valid && out_ready.
  - out_data holds stable while out_valid && !out_ready.
  - At most one frame is held; no new START while out_valid == 1.
  - A handshake in the same cycle as the IDLE evaluation does not start a read that cycle; the start comes one cycle later.
- en low mid-read: the sequence runs to IDLE normally, then stays in IDLE.
- Counters saturate at 16'hFFFF; no wrap.
- fifo_count is compared unsigned at 12 bits; it may change freely during a read and is sampled only in IDLE.
- Unused state encodings -> IDLE.
- rst mid-read: the controller returns to IDLE immediately. The reader is reset by the same rst.

Decomposition:
- Shared mac_rx package holds:
  - state localparams IDLE, START, BUSY, RELEASE, ABORT (3-bit);
  - default FRAME_BYTES and HDR_BYTE;
  - the 96-bit frame width constant.
- One natural sub-module: mac_rx_sat_cnt16, a 16-bit saturating counter with inc and synchronous clear, instantiated three times.

Test Plan:
- Start gating: fifo_count = 11 then 12, en = 1 -> rd_fs rises 1 cycle after count reaches 12; it never rises while count stays at 11.
- Good frame: rd_res = 96'hAA0102030405060708090A0B, rd_fd pulsed after 14 cycles -> out_valid next cycle, out_data equals rd_res, frame_cnt = 1; rd_fs low in RELEASE; IDLE after rd_fd falls.
- Bad header: rd_res[0:7] = 8'h55 -> out_valid stays 0, drop_cnt = 1, frame_cnt unchanged.
- Backpressure: out_ready = 0 for 50 cycles with fifo_count = 40 -> no second rd_fs; out_data stable; second read starts 1 cycle after the handshake.
- Timeout: TIMEOUT = 16, rd_fd held 0 -> rd_fs drops after exactly 16 BUSY cycles, rd_err high for 1 cycle, tout_cnt = 1, return to IDLE.
- Reset and saturation: rst asserted in BUSY -> all outputs 0 next cycle. Preload drop_cnt to 16'hFFFF and send a bad frame -> drop_cnt remains 16'hFFFF.
